// File: rtl/hevc_quant_pkg.sv
// rtl/hevc_quant_pkg.sv - shared constants, state type and qp helpers for the HEVC quantizer
package hevc_quant_pkg;

  localparam int MAX_QP    = 51;
  localparam int INTRA_OFF = 171;
  localparam int INTER_OFF = 85;

  localparam logic [15:0] QTAB [6] = '{16'd26214, 16'd23302, 16'd20560,
                                       16'd18396, 16'd16384, 16'd14564};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [5:0] clamp_qp(input logic [5:0] qp);
    return (qp > 6'(MAX_QP)) ? 6'(MAX_QP) : qp;
  endfunction

  // qbits = 14 + qp/6 + (15 - bit_depth - log2(n))
  function automatic logic [5:0] qbits(input logic [5:0] qp, input int n, input int bit_depth);
    int qi;
    int r;
    qi = {26'd0, qp};
    r  = 14 + qi / 6 + 15 - bit_depth - $clog2(n);
    return 6'(r);
  endfunction

endpackage

// File: rtl/hevc_quant_pe.sv
// rtl/hevc_quant_pe.sv - two-stage single-coefficient quantization pipeline
module hevc_quant_pe #(
  parameter int CW = 16,
  parameter int IW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [CW-1:0] c,
  input  logic [15:0]          q,
  input  logic [5:0]           qbits,
  input  logic [47:0]          off,
  input  logic                 valid_in,
  input  logic [IW-1:0]        idx_in,
  output logic signed [CW-1:0] level,
  output logic                 valid_out,
  output logic [IW-1:0]        idx_out,
  output logic                 empty
);

  localparam logic [47:0]   MAG_MAX = 48'((64'd1 << (CW-1)) - 64'd1);
  localparam logic [CW-1:0] MAX_L   = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CW-1:0] MIN_L   = {1'b1, {(CW-1){1'b0}}};

  logic [CW-1:0] mag;
  logic [47:0]   a_s1;
  logic          neg_s1;
  logic          v_s1;
  logic [IW-1:0] idx_s1;
  logic [47:0]   m;
  logic [CW-1:0] lv;

  // two's-complement magnitude: -32768 maps to 0x8000, read as unsigned 32768
  always_comb begin
    mag = c[CW-1] ? (~c + 1'b1) : c;
  end

  always_comb begin
    m = (a_s1 + off) >> qbits;
    if (neg_s1)
      lv = (m > MAG_MAX + 48'd1) ? MIN_L : (~m[CW-1:0] + 1'b1);
    else
      lv = (m > MAG_MAX) ? MAX_L : m[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1      <= '0;
      neg_s1    <= 1'b0;
      v_s1      <= 1'b0;
      idx_s1    <= '0;
      level     <= '0;
      valid_out <= 1'b0;
      idx_out   <= '0;
    end else begin
      a_s1      <= 48'(mag) * 48'(q);
      neg_s1    <= c[CW-1];
      v_s1      <= valid_in;
      idx_s1    <= idx_in;
      level     <= lv;
      valid_out <= v_s1;
      idx_out   <= idx_s1;
    end
  end

  assign empty = ~v_s1 & ~valid_out;

endmodule

// File: rtl/hevc_quant_n_seq.sv
// rtl/hevc_quant_n_seq.sv - sequential N x N forward quantizer: FSM, input latch, level array
module hevc_quant_n_seq
  import hevc_quant_pkg::*;
#(
  parameter int N         = 4,
  parameter int BIT_DEPTH = 8,
  parameter int CW        = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [5:0]                          qp,
  input  logic                                intra,
  input  logic signed [0:N-1][0:N-1][CW-1:0]  x,
  output logic signed [0:N-1][0:N-1][CW-1:0]  y,
  output logic [$clog2(N*N):0]                nz_count,
  output logic                                busy,
  output logic                                done
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int LN = $clog2(N);

  state_t                       state;
  logic                         start_q;
  logic [0:N-1][0:N-1][CW-1:0]  x_l;
  logic [15:0]                  q_l;
  logic [5:0]                   qb_l;
  logic [47:0]                  off_l;
  logic [IW-1:0]                idx;

  logic [5:0]  qp_c;
  logic [5:0]  qb_c;
  logic [2:0]  qsel;
  logic [47:0] off_c;

  logic signed [CW-1:0] pe_level;
  logic                 pe_valid;
  logic [IW-1:0]        pe_idx;
  logic                 pe_empty;

  always_comb begin
    qp_c  = clamp_qp(qp);
    qb_c  = qbits(qp_c, N, BIT_DEPTH);
    qsel  = 3'(qp_c % 6'd6);
    off_c = (intra ? 48'(INTRA_OFF) : 48'(INTER_OFF)) << (qb_c - 6'd9);
  end

  hevc_quant_pe #(.CW(CW), .IW(IW)) u_pe (
    .clk       (clk),
    .rst_n     (reset),
    .c         ($signed(x_l[idx[IW-1:LN]][idx[LN-1:0]])),
    .q         (q_l),
    .qbits     (qb_l),
    .off       (off_l),
    .valid_in  (state == RUN),
    .idx_in    (idx),
    .level     (pe_level),
    .valid_out (pe_valid),
    .idx_out   (pe_idx),
    .empty     (pe_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      x_l      <= '0;
      q_l      <= '0;
      qb_l     <= '0;
      off_l    <= '0;
      idx      <= '0;
      y        <= '0;
      nz_count <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      start_q <= start;
      if (pe_valid) begin
        y[pe_idx[IW-1:LN]][pe_idx[LN-1:0]] <= pe_level;
        if (pe_level != '0)
          nz_count <= nz_count + 1'b1;
      end
      case (state)
        IDLE, DONE: begin
          if (start && !start_q) begin
            x_l      <= x;
            q_l      <= QTAB[qsel];
            qb_l     <= qb_c;
            off_l    <= off_c;
            idx      <= '0;
            y        <= '0;
            nz_count <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          idx <= idx + 1'b1;
          if (idx == IW'(NN - 1))
            state <= DRAIN;
        end
        DRAIN: begin
          if (pe_empty) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hevc_quant_n_seq.md
Name: hevc_quant_n_seq

Overview:
- Forward scalar quantizer placed directly downstream of the N-point 2D DCT.
- Consumes the DCT's N×N signed 16-bit coefficient array when `start` is asserted (DCT `done` drives it) and walks the coefficients one per cycle through a 2-stage quantization pipeline.
- Produces an N×N array of HEVC levels, a non-zero count, and a level `done` for the downstream entropy/scan stage.

Parameters:
- N, 4, transform size; legal values 4, 8, 16, 32.
- BIT_DEPTH, 8, sample bit depth; sets the transform shift.
- CW, 16, coefficient and level width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  request; acts on its rising edge only.
- qp  in  6  quantization parameter; values above 51 are clamped to 51.
- intra  in  1  1 = intra rounding offset (171), 0 = inter offset (85).
- x  in  signed [CW-1:0] [0:N-1][0:N-1]  coefficient array from the DCT.
- y  out  signed [CW-1:0] [0:N-1][0:N-1]  quantized levels.
- nz_count  out  $clog2(N*N)+1  number of non-zero levels in y.
- busy  out  1  high from accepted start until done.
- done  out  1  level; high from completion until the next accepted start.

Behaviour:
- Reset (reset==0, asynchronous): state IDLE; y all 0; nz_count 0; busy 0; done 0; internal index and pipeline valids cleared.
  - Reset mid-operation aborts the job; no partial done is produced.
- Start detection: start_q is a registered copy of start. An accepted start is start & ~start_q while state is IDLE or DONE.
  - Any start edge while busy is ignored.
  - A start held high for many cycles yields exactly one job.
- On an accepted start:
  - x, clamped qp and intra are latched into a local copy; the caller may change x afterwards.
  - done and nz_count clear; busy sets; state goes to RUN.
- States: IDLE → RUN → DRAIN → DONE → (accepted start) → RUN.
  - RUN: issue coefficient idx = 0 … N*N-1 in raster order (row-major), one per cycle. After idx N*N-1 is issued, go to DRAIN.
  - DRAIN: wait until both pipeline stages are empty, then go to DONE. In DONE: busy=0, done=1.
- Latency: done rises on the (N*N+3)th rising clk edge after the edge that accepted start. For N=4 this is 19 edges.
- Arithmetic, per coefficient c:
  - Q = QTAB[qp%6], with QTAB = {26214, 23302, 20560, 18396, 16384, 14564}.
  - shift = 15 − BIT_DEPTH − log2(N).
  - qbits = 14 + qp/6 + shift.
  - off = (intra ? 171 : 85) << (qbits − 9).
  - Stage 1 (register): a = |c| × Q. Use 48-bit unsigned; |−32768| = 32768 exactly.
  - Stage 2 (register): m = (a + off) >> qbits. Level = sign(c)·m, saturated to [−2^(CW−1), 2^(CW−1)−1]. Write the level to y[idx] carried down the pipe.
  - If the level is non-zero, nz_count increments in the same cycle.
  - c = 0 always gives level 0.
- y entries not yet written during RUN/DRAIN hold 0, because they are cleared at start. y is stable while done=1.
- qp, intra and x changing during RUN have no effect.

Decomposition:
- Package `hevc_quant_pkg`:
  - QTAB constant array.
  - Offset constants INTRA_OFF=171 and INTER_OFF=85.
  - MAX_QP=51.
  - Function qbits(qp, N, BIT_DEPTH).
  - Function clamp_qp.
- Sub-module `hevc_quant_pe`: the 2-stage single-coefficient pipeline.
  - Inputs: c, Q, qbits, off, valid_in, idx_in.
  - Outputs: level, valid_out, idx_out.
  - It has its own async active-low reset.
- Top level holds the FSM, start edge detect, input latch, y register array and nz_count.

Test Plan:
- N=4, qp=4, intra=1, x all 0 → y all 0, nz_count=0; done exactly 19 edges after the start edge.
- x[0][0]=1000, x[1][1]=−1000, rest 0, qp=4, intra=1 (Q=16384, qbits=19, off=175104) → y[0][0]=31, y[1][1]=−31, others 0, nz_count=2.
- Deadzone: x all 16, qp=4, intra=1 → (262144+175104)>>19=0 → y all 0, nz_count=0. With intra=0, result is still 0.
- Higher qp: x[2][3]=1000, qp=22 (qbits=22), intra=1 → y[2][3]=4, nz_count=1. Repeat with qp=60 → treated as 51.
- Extreme value: x[0][0]=32767, x[3][3]=−32768, qp=0, intra=1 → y[0][0]=1638, y[3][3]=−1638, no saturation.
- Control:
  - Start held for 3 cycles gives one job.
  - A start edge during RUN is ignored.
  - reset=0 at idx 7 clears y, nz_count, busy and done immediately.
  - A new start after release runs a full job normally.
